// File: rtl/load_unit_if.sv
// Load unit signal bundle: M-stage request, data-bus read port and response.
// master = load unit side, slave = pipeline/memory environment side.
interface load_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_rt;
  logic              bus_rd;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_rdata;
  logic              bus_ack;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_exc;
  logic [ADDR_W-1:0] rsp_badaddr;

  modport master (
    input  flush, req_valid, req_op, req_addr, req_rt, bus_rdata, bus_ack, rsp_ready,
    output req_ready, bus_rd, bus_addr, rsp_valid, rsp_data, rsp_exc, rsp_badaddr
  );

  modport slave (
    output flush, req_valid, req_op, req_addr, req_rt, bus_rdata, bus_ack, rsp_ready,
    input  req_ready, bus_rd, bus_addr, rsp_valid, rsp_data, rsp_exc, rsp_badaddr
  );
endinterface

// File: rtl/load_unit.sv
// MIPS32 memory-stage load controller: alignment check, wait-stated word read,
// byte/halfword extraction and lwl/lwr merge, registered response with exception code.
module load_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter bit          LWLR_EN    = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  load_unit_if.master lu
);

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpLb  = 3'b001;
  localparam logic [2:0] OpLbu = 3'b010;
  localparam logic [2:0] OpLh  = 3'b011;
  localparam logic [2:0] OpLhu = 3'b100;
  localparam logic [2:0] OpLwl = 3'b101;
  localparam logic [2:0] OpLwr = 3'b110;
  localparam logic [2:0] OpIll = 3'b111;

  // Counter only has to reach TIMEOUT-1; the timeout fires on the cycle that would make it TIMEOUT.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rt_q, rt_d;
  logic              bus_rd_q, bus_rd_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_exc_q, rsp_exc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        req_illegal;
  logic        req_misaligned;
  logic        timeout_hit;

  // Effective byte lane in bus_rdata; big-endian mirrors the lane order.
  assign lane     = addr_q[1:0] ^ {2{BIG_ENDIAN}};
  assign byte_sel = lu.bus_rdata[{lane, 3'b000} +: 8];
  assign half_sel = lu.bus_rdata[{lane[1], 4'b0000} +: 16];

  assign req_illegal = (lu.req_op == OpIll) ||
                       (!LWLR_EN && (lu.req_op == OpLwl || lu.req_op == OpLwr));
  assign req_misaligned = ((lu.req_op == OpLw) && (lu.req_addr[1:0] != 2'b00)) ||
                          ((lu.req_op == OpLh || lu.req_op == OpLhu) && lu.req_addr[0]);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  // Extract/extend the addressed data and merge lwl/lwr with the captured rt.
  always_comb begin
    load_data = lu.bus_rdata;
    case (op_q)
      OpLb:  load_data = {{24{byte_sel[7]}}, byte_sel};
      OpLbu: load_data = {24'h0, byte_sel};
      OpLh:  load_data = {{16{half_sel[15]}}, half_sel};
      OpLhu: load_data = {16'h0, half_sel};
      OpLwl: begin
        case (lane)
          2'd0:    load_data = {lu.bus_rdata[7:0], rt_q[23:0]};
          2'd1:    load_data = {lu.bus_rdata[15:0], rt_q[15:0]};
          2'd2:    load_data = {lu.bus_rdata[23:0], rt_q[7:0]};
          default: load_data = lu.bus_rdata;
        endcase
      end
      OpLwr: begin
        case (lane)
          2'd0:    load_data = lu.bus_rdata;
          2'd1:    load_data = {rt_q[31:24], lu.bus_rdata[31:8]};
          2'd2:    load_data = {rt_q[31:16], lu.bus_rdata[31:16]};
          default: load_data = {rt_q[31:8], lu.bus_rdata[31:24]};
        endcase
      end
      default: load_data = lu.bus_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    rt_d        = rt_q;
    bus_rd_d    = bus_rd_q;
    bus_addr_d  = bus_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_exc_d   = rsp_exc_q;
    cnt_d       = cnt_q;
    case (state_q)
      StIdle: begin
        if (lu.req_valid && !lu.flush) begin
          op_d   = lu.req_op;
          addr_d = lu.req_addr;
          rt_d   = lu.req_rt;
          cnt_d  = '0;
          if (req_illegal) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_exc_d   = 2'b11;
            rsp_data_d  = '0;
          end else if (req_misaligned) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_exc_d   = 2'b01;
            rsp_data_d  = '0;
          end else begin
            state_d    = StWait;
            bus_rd_d   = 1'b1;
            bus_addr_d = {lu.req_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      StWait: begin
        // Flush wins over a same-cycle ack; ack wins over timeout.
        if (lu.flush) begin
          state_d  = StIdle;
          bus_rd_d = 1'b0;
        end else if (lu.bus_ack) begin
          state_d     = StResp;
          bus_rd_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_exc_d   = 2'b00;
          rsp_data_d  = load_data;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (timeout_hit) begin
            state_d     = StResp;
            bus_rd_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_exc_d   = 2'b10;
            rsp_data_d  = '0;
          end
        end
      end
      StResp: begin
        if (lu.flush || lu.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      addr_q      <= '0;
      rt_q        <= '0;
      bus_rd_q    <= 1'b0;
      bus_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rt_q        <= rt_d;
      bus_rd_q    <= bus_rd_d;
      bus_addr_q  <= bus_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_exc_q   <= rsp_exc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign lu.req_ready   = (state_q == StIdle);
  assign lu.bus_rd      = bus_rd_q;
  assign lu.bus_addr    = bus_addr_q;
  assign lu.rsp_valid   = rsp_valid_q;
  assign lu.rsp_data    = rsp_data_q;
  assign lu.rsp_exc     = rsp_exc_q;
  assign lu.rsp_badaddr = addr_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed scenarios plus randomized loads
// against a behavioural memory-view model.
module tb_load_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_unit_if #(.ADDR_W(32)) ua ();
  load_unit_if #(.ADDR_W(32)) ub ();

  // Little-endian, long timeout, lwl/lwr enabled.
  load_unit #(.ADDR_W(32), .TIMEOUT(16), .BIG_ENDIAN(1'b0), .LWLR_EN(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .lu    (ua)
  );

  // Big-endian, short timeout, lwl/lwr disabled.
  load_unit #(.ADDR_W(32), .TIMEOUT(4), .BIG_ENDIAN(1'b1), .LWLR_EN(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .lu    (ub)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected exception code from the op/alignment rules.
  function automatic logic [1:0] ref_exc(input logic [2:0] op, input logic [31:0] a,
                                         input bit lwlr_en);
    int o = int'(op);
    if (o == 7 || (!lwlr_en && (o == 5 || o == 6))) return 2'd3;
    if (o == 0 && (a % 4) != 0) return 2'd1;
    if ((o == 3 || o == 4) && (a % 2) != 0) return 2'd1;
    return 2'd0;
  endfunction

  // Expected load result, viewing the word as 4 bytes numbered from its LSB.
  function automatic logic [31:0] ref_data(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] rt, input logic [31:0] w,
                                           input bit be);
    int k = int'(a % 4);
    logic [31:0] v;
    if (be) k = 3 - k;
    case (int'(op))
      1: begin v = (w >> (8 * k)) & 32'hFF;   return (v >= 32'h80)   ? (v | 32'hFFFF_FF00) : v; end
      2: return (w >> (8 * k)) & 32'hFF;
      3: begin v = (w >> (16 * (k / 2))) & 32'hFFFF; return (v >= 32'h8000) ? (v | 32'hFFFF_0000) : v; end
      4: return (w >> (16 * (k / 2))) & 32'hFFFF;
      5: return (w << (8 * (3 - k))) | (rt & ((32'h1 << (8 * (3 - k))) - 32'h1));
      6: return (w >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)));
      default: return w;
    endcase
  endfunction

  // One complete load on dut_a: accept, optional bus access, stall, handshake.
  task automatic load_a(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] w, input int waits, input int stall);
    logic [1:0]  e = ref_exc(op, addr, 1'b1);
    logic [31:0] d = (e != 2'd0) ? 32'h0 : ref_data(op, addr, rt, w, 1'b0);
    @(negedge clk);
    check("req_ready_idle", ua.req_ready, 1);
    ua.req_valid = 1'b1; ua.req_op = op; ua.req_addr = addr; ua.req_rt = rt;
    @(negedge clk);
    ua.req_valid = 1'b0; ua.req_op = $urandom; ua.req_rt = $urandom;
    if (e == 2'd0) begin
      check("bus_rd_start", ua.bus_rd, 1);
      check("bus_addr", ua.bus_addr, {addr[31:2], 2'b00});
      for (int i = 0; i < waits; i++) begin
        check("no_early_rsp", ua.rsp_valid, 0);
        @(negedge clk);
      end
      check("bus_rd_held", ua.bus_rd, 1);
      ua.bus_ack = 1'b1; ua.bus_rdata = w;
      @(negedge clk);
      ua.bus_ack = 1'b0; ua.bus_rdata = $urandom;
      check("bus_rd_drop", ua.bus_rd, 0);
    end else begin
      check("no_bus_rd", ua.bus_rd, 0);
    end
    check("rsp_valid_latency", ua.rsp_valid, 1);
    for (int i = 0; i <= stall; i++) begin
      check("rsp_data", ua.rsp_data, d);
      check("rsp_exc", ua.rsp_exc, e);
      check("rsp_badaddr", ua.rsp_badaddr, addr);
      if (i < stall) begin
        @(negedge clk);
        check("rsp_valid_stall", ua.rsp_valid, 1);
      end
    end
    ua.rsp_ready = 1'b1;
    @(negedge clk);
    ua.rsp_ready = 1'b0;
    check("rsp_valid_after_hs", ua.rsp_valid, 0);
  endtask

  initial begin
    {ua.flush, ua.req_valid, ua.req_op, ua.req_addr, ua.req_rt, ua.bus_rdata, ua.bus_ack,
     ua.rsp_ready} = '0;
    {ub.flush, ub.req_valid, ub.req_op, ub.req_addr, ub.req_rt, ub.bus_rdata, ub.bus_ack,
     ub.rsp_ready} = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check("rst_req_ready", ua.req_ready, 1);
    check("rst_bus_rd", ua.bus_rd, 0);
    check("rst_bus_addr", ua.bus_addr, 0);
    check("rst_rsp_valid", ua.rsp_valid, 0);
    check("rst_rsp_data", ua.rsp_data, 0);
    check("rst_rsp_exc", ua.rsp_exc, 0);
    check("rst_badaddr", ua.rsp_badaddr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed loads
    load_a(3'b001, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
    check("lb_literal", ref_data(3'b001, 32'h103, 32'h0, 32'h80FF1234, 1'b0), 32'hFFFFFF80);
    load_a(3'b100, 32'h202, 32'h0, 32'hBEEF0000, 3, 0);
    load_a(3'b000, 32'h301, 32'h0, 32'h0, 0, 1);
    load_a(3'b111, 32'h304, 32'h0, 32'h0, 0, 0);
    load_a(3'b101, 32'h401, 32'h11223344, 32'hAABBCCDD, 1, 0);
    load_a(3'b110, 32'h401, 32'h11223344, 32'hAABBCCDD, 0, 3);
    check("lwl_literal", ref_data(3'b101, 32'h401, 32'h11223344, 32'hAABBCCDD, 1'b0), 32'hCCDD3344);
    check("lwr_literal", ref_data(3'b110, 32'h401, 32'h11223344, 32'hAABBCCDD, 1'b0), 32'h11AABBCC);

    // Flush in WAIT with a concurrent ack: no response, back to idle
    @(negedge clk);
    ua.req_valid = 1'b1; ua.req_op = 3'b000; ua.req_addr = 32'h500;
    @(negedge clk);
    ua.req_valid = 1'b0;
    check("flush_wait_bus_rd", ua.bus_rd, 1);
    ua.flush = 1'b1; ua.bus_ack = 1'b1; ua.bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    ua.flush = 1'b0; ua.bus_ack = 1'b0;
    check("flush_wait_bus_rd_drop", ua.bus_rd, 0);
    check("flush_wait_no_rsp", ua.rsp_valid, 0);
    check("flush_wait_ready", ua.req_ready, 1);

    // Request together with flush in IDLE is ignored
    ua.req_valid = 1'b1; ua.flush = 1'b1; ua.req_op = 3'b000; ua.req_addr = 32'h504;
    @(negedge clk);
    ua.req_valid = 1'b0; ua.flush = 1'b0;
    check("flush_idle_bus_rd", ua.bus_rd, 0);
    check("flush_idle_rsp", ua.rsp_valid, 0);
    check("flush_idle_ready", ua.req_ready, 1);

    // Flush in RESP drops the response
    ua.req_valid = 1'b1; ua.req_op = 3'b111; ua.req_addr = 32'h508;
    @(negedge clk);
    ua.req_valid = 1'b0;
    check("flush_resp_valid", ua.rsp_valid, 1);
    ua.flush = 1'b1;
    @(negedge clk);
    ua.flush = 1'b0;
    check("flush_resp_dropped", ua.rsp_valid, 0);
    check("flush_resp_ready", ua.req_ready, 1);

    // Asynchronous reset in WAIT; the pending ack is ignored
    ua.req_valid = 1'b1; ua.req_op = 3'b000; ua.req_addr = 32'h600;
    @(negedge clk);
    ua.req_valid = 1'b0;
    check("rst_wait_bus_rd", ua.bus_rd, 1);
    ua.bus_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_wait_async_bus_rd", ua.bus_rd, 0);
    check("rst_wait_async_ready", ua.req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; ua.bus_ack = 1'b0;
    @(negedge clk);
    check("rst_wait_no_rsp", ua.rsp_valid, 0);

    // dut_b: timeout after 4 wait cycles
    @(negedge clk);
    ub.req_valid = 1'b1; ub.req_op = 3'b000; ub.req_addr = 32'h40;
    @(negedge clk);
    ub.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_bus_rd_held", ub.bus_rd, 1);
      @(negedge clk);
    end
    check("to_bus_rd_drop", ub.bus_rd, 0);
    check("to_rsp_valid", ub.rsp_valid, 1);
    check("to_rsp_exc", ub.rsp_exc, 2'b10);
    check("to_rsp_data", ub.rsp_data, 0);
    check("to_badaddr", ub.rsp_badaddr, 32'h40);
    ub.rsp_ready = 1'b1;
    @(negedge clk);
    ub.rsp_ready = 1'b0;

    // dut_b: big-endian lbu at offset 0 selects the most significant byte
    ub.req_valid = 1'b1; ub.req_op = 3'b010; ub.req_addr = 32'h0;
    @(negedge clk);
    ub.req_valid = 1'b0;
    ub.bus_ack = 1'b1; ub.bus_rdata = 32'h12345678;
    @(negedge clk);
    ub.bus_ack = 1'b0;
    check("be_lbu_valid", ub.rsp_valid, 1);
    check("be_lbu_data", ub.rsp_data, 32'h12);
    check("be_lbu_model", ub.rsp_data, ref_data(3'b010, 32'h0, 32'h0, 32'h12345678, 1'b1));
    ub.rsp_ready = 1'b1;
    @(negedge clk);
    ub.rsp_ready = 1'b0;

    // dut_b: lwl is illegal with lwl/lwr disabled
    ub.req_valid = 1'b1; ub.req_op = 3'b101; ub.req_addr = 32'h81;
    @(negedge clk);
    ub.req_valid = 1'b0;
    check("b_lwl_no_bus", ub.bus_rd, 0);
    check("b_lwl_exc", ub.rsp_exc, ref_exc(3'b101, 32'h81, 1'b0));
    check("b_lwl_exc_lit", ub.rsp_exc, 2'b11);
    ub.rsp_ready = 1'b1;
    @(negedge clk);
    ub.rsp_ready = 1'b0;

    // Randomized loads on dut_a
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  op   = 3'($urandom_range(0, 7));
      logic [31:0] addr = $urandom & 32'h0000_FFFF;
      load_a(op, addr, $urandom, $urandom, int'($urandom_range(0, 5)),
             int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
